// File: rtl/tdm_pkg.sv
// Shared constants, FSM state type and channel-walk helpers for the TDM scanner.
// Channel-mask helpers serve the optional TDM_SCANNER_MASK_EN build; with all
// channels enabled they reduce to a plain 0..3 walk.
package tdm_pkg;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned SEL_W  = 2;

    typedef enum logic {
        IDLE,
        SCAN
    } state_e;

    // Lowest enabled channel; 0 when the mask is empty.
    function automatic logic [SEL_W-1:0] first_ch(input logic [NUM_CH-1:0] m);
        logic [SEL_W-1:0] r;
        r = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (m[i]) r = SEL_W'(i);
        end
        return r;
    endfunction

    // Highest enabled channel; marks the frame end.
    function automatic logic [SEL_W-1:0] last_ch(input logic [NUM_CH-1:0] m);
        logic [SEL_W-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (m[i]) r = SEL_W'(i);
        end
        return r;
    endfunction

    // Next enabled channel strictly above cur; cur itself if none remain.
    function automatic logic [SEL_W-1:0] next_ch(input logic [NUM_CH-1:0] m,
                                                 input logic [SEL_W-1:0]  cur);
        logic [SEL_W-1:0] r;
        r = cur;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (m[i] && (i > int'(cur))) r = SEL_W'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/tdm_scanner_if.sv
// Signal bundle between the TDM scanner, its 4:1 mux and the frame consumer.
// Optional macro TDM_SCANNER_MASK_EN adds the per-channel enable ch_en.
interface tdm_scanner_if;
    import tdm_pkg::*;

    logic              run;
    logic              F;
    logic [SEL_W-1:0]  S;
    logic [NUM_CH-1:0] frame;
    logic              frame_valid;
    logic              frame_ack;
    logic              overrun;
    logic              busy;
`ifdef TDM_SCANNER_MASK_EN
    logic [NUM_CH-1:0] ch_en;

    modport master (
        input  run, F, frame_ack, ch_en,
        output S, frame, frame_valid, overrun, busy
    );

    modport slave (
        output run, F, frame_ack, ch_en,
        input  S, frame, frame_valid, overrun, busy
    );
`else
    modport master (
        input  run, F, frame_ack,
        output S, frame, frame_valid, overrun, busy
    );

    modport slave (
        output run, F, frame_ack,
        input  S, frame, frame_valid, overrun, busy
    );
`endif

endinterface

// File: rtl/tdm_scanner_dwell_counter.sv
// Dwell counter: counts 0..DWELL-1 while enabled and wraps; flags the
// terminal count and the SETTLE sample point.
module dwell_counter #(
    parameter int unsigned DWELL  = 4,
    parameter int unsigned SETTLE = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic clear,
    output logic tc,
    output logic match
);

    logic [7:0] cnt_q;

    assign tc    = (cnt_q == 8'(DWELL - 1));
    assign match = (cnt_q == 8'(SETTLE));

    // Count within the dwell; clear has priority so IDLE always holds 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable) begin
            cnt_q <= tc ? 8'd0 : cnt_q + 8'd1;
        end
    end

endmodule

// File: rtl/tdm_scanner.sv
// TDM scanner: walks a 4:1 mux select across the channels, samples F at the
// SETTLE point of each dwell and delivers one 4-bit frame per sweep with a
// valid/ack handshake and a sticky overrun flag.
// Optional macro TDM_SCANNER_MASK_EN: ch_en skips disabled channels.
module tdm_scanner
    import tdm_pkg::*;
#(
    parameter int unsigned DWELL  = 4,
    parameter int unsigned SETTLE = 2
) (
    input logic           clk,
    input logic           rst_n,
    tdm_scanner_if.master bus
);

    state_e            state_q;
    logic [SEL_W-1:0]  sel_q;
    logic [NUM_CH-1:0] shadow_q;
    logic [NUM_CH-1:0] frame_q;
    logic              frame_valid_q;
    logic              overrun_q;

    logic [NUM_CH-1:0] en_q;
    logic [NUM_CH-1:0] live_en;
    logic              start_ok;
    logic              load_en;
    logic              frame_end;
    logic              dwell_tc;
    logic              dwell_match;

`ifdef TDM_SCANNER_MASK_EN
    assign live_en  = bus.ch_en;
    assign start_ok = |bus.ch_en;

    // Channel mask is frozen at frame start so a sweep never changes shape.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q <= '0;
        end else if (load_en) begin
            en_q <= live_en;
        end
    end
`else
    assign live_en  = '1;
    assign en_q     = '1;
    assign start_ok = 1'b1;
`endif

    assign frame_end = (state_q == SCAN) && dwell_tc && (sel_q == last_ch(en_q));
    // A new frame starts from IDLE or back-to-back at the end of the previous one.
    assign load_en   = bus.run && start_ok && ((state_q == IDLE) || frame_end);

    dwell_counter #(
        .DWELL  (DWELL),
        .SETTLE (SETTLE)
    ) u_dwell (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (state_q == SCAN),
        .clear  (state_q == IDLE),
        .tc     (dwell_tc),
        .match  (dwell_match)
    );

    // Scan FSM, channel select, sample capture and frame handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            sel_q         <= '0;
            shadow_q      <= '0;
            frame_q       <= '0;
            frame_valid_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            if (load_en) begin
                state_q <= SCAN;
                sel_q   <= first_ch(live_en);
            end else if (frame_end) begin
                state_q <= IDLE;
                sel_q   <= '0;
            end else if ((state_q == SCAN) && dwell_tc) begin
                sel_q <= next_ch(en_q, sel_q);
            end

            if ((state_q == SCAN) && dwell_match) begin
                shadow_q[sel_q] <= bus.F;
            end

            // Completion beats a coincident ack: the ack consumes the old frame.
            if (frame_end) begin
                frame_q       <= shadow_q & en_q;
                frame_valid_q <= 1'b1;
                if (frame_valid_q && !bus.frame_ack) begin
                    overrun_q <= 1'b1;
                end
            end else if (bus.frame_ack) begin
                frame_valid_q <= 1'b0;
            end
        end
    end

    assign bus.S           = sel_q;
    assign bus.frame       = frame_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.overrun     = overrun_q;
    assign bus.busy        = (state_q == SCAN);

endmodule

// File: doc/tdm_scanner.md
TDM_SCANNER -- requirements
Module: tdm_scanner

Interface
REQ-001 SHALL have parameter DWELL, default 4: clock cycles spent on each channel; legal range 3..255.
REQ-002 SHALL have parameter SETTLE, default 2: cycle index within the dwell at which F is sampled; legal range 1..DWELL-2.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 run  in  1  level; 1 = scan continuously, 0 = stop after the current frame.
REQ-006 F  in  1  output of the downstream-fed 4:1 mux (selected channel value).
REQ-007 S  out  2  select driven to the 4:1 mux; channel currently addressed.
REQ-008 frame  out  4  last completed frame; bit k = sample of channel k.
REQ-009 frame_valid  out  1  frame holds an unacknowledged result.
REQ-010 frame_ack  in  1  consumer acknowledge; clears frame_valid.
REQ-011 overrun  out  1  sticky; a frame completed while frame_valid was still 1.
REQ-012 busy  out  1  1 whenever the FSM is not in IDLE.

Function
REQ-013 FSM states SHALL be IDLE and SCAN; IDLE->SCAN when run=1, SCAN->IDLE at frame end when run=0.
REQ-014 On IDLE->SCAN, S SHALL be 0 and dwell count 0 in the first SCAN cycle.
REQ-015 In SCAN, the dwell count SHALL increment every cycle, and wrap to 0 after DWELL-1 while S advances by 1.
REQ-016 When dwell count == SETTLE, F SHALL be captured into shadow bit S.
REQ-017 At dwell count DWELL-1 with S==3, frame SHALL load shadow on the next edge, and frame_valid SHALL go to 1 on that same edge.
REQ-018 After frame end, S SHALL wrap 3->0 if run=1; otherwise the FSM SHALL enter IDLE with S=0.
REQ-019 Deasserting run mid-frame SHALL NOT abort the frame; the frame completes and is delivered.
REQ-020 The first frame_valid SHALL rise exactly 4*DWELL cycles after the cycle in which run was sampled 1 in IDLE.
REQ-021 frame_valid SHALL clear on the edge after frame_ack=1; frame_ack while frame_valid=0 SHALL be ignored.
REQ-022 When a frame completes while frame_valid=1 and no frame_ack occurs that cycle, frame SHALL be overwritten and overrun SHALL set.
REQ-023 When frame_ack and frame completion coincide, the new frame SHALL load, frame_valid SHALL stay 1, and overrun SHALL NOT set.
REQ-024 overrun SHALL clear only on reset.
REQ-025 S SHALL be stable for the whole dwell; F sampled at SETTLE gives the mux SETTLE cycles of settling.

Reset
REQ-026 rst_n=0 SHALL immediately force: FSM=IDLE, S=0, dwell count=0, shadow=0, frame=0, frame_valid=0, overrun=0, busy=0.
REQ-027 Reset mid-frame SHALL discard the partial frame; the first scan after release starts at channel 0.

Configuration
REQ-028 Macro TDM_SCANNER_MASK_EN defined: extra input ch_en[3:0]; channels with ch_en[k]=0 SHALL be skipped without dwell, and frame bit k SHALL be 0.
REQ-029 With TDM_SCANNER_MASK_EN: frame end SHALL be the dwell end of the highest enabled channel, and ch_en sampled at frame start SHALL hold for that frame.
REQ-030 With TDM_SCANNER_MASK_EN: ch_en==0 SHALL keep the FSM in IDLE regardless of run.
REQ-031 Without TDM_SCANNER_MASK_EN: the ch_en port SHALL be absent and all four channels scanned.

Structure
REQ-032 Package tdm_pkg SHALL hold NUM_CH=4, SEL_W=2, and the state enum {IDLE, SCAN}.
REQ-033 The dwell counter SHALL be a sub-module dwell_counter (enable, clear, terminal-count and match-SETTLE outputs).

Verification
REQ-034 DWELL=4, SETTLE=2, run=1, F driven from I=4'b1010 via mux -> frame=4'b1010 and frame_valid rises 16 cycles after run.
REQ-035 Pulse run for 1 cycle -> exactly one frame, then busy=0 and S=0.
REQ-036 Withhold frame_ack for two frames -> overrun=1 and frame holds the second frame; ack coinciding with completion -> overrun stays 0.
REQ-037 rst_n low at channel 2 mid-dwell -> all outputs 0 at once; after release with run=1, S sequence restarts 0,1,2,3.
REQ-038 TDM_SCANNER_MASK_EN, ch_en=4'b0101, I=4'b1111 -> only S=0,2 visited, frame=4'b0101, frame_valid at 2*DWELL cycles.
